// File: rtl/types_pkg.sv
// Shared types and defaults for the data-memory responder.
// The request struct is sized by the package widths; the top defaults to the same widths.
package types_pkg;

    localparam int DMEM_DATA_W    = 16;
    localparam int DMEM_ADDR_W    = 16;
    localparam int DMEM_DEPTH_DEF = 256;
    localparam int DMEM_WAIT_DEF  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    typedef struct packed {
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_array.sv
// Word array with a synchronous write port and a combinational read port.
// Isolated so it can be replaced by a vendor RAM macro.
module dmem_array #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 16,
    parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store at a time, stalls the
// pipeline through busy, and pulses ack after WAIT_CYCLES wait states.
module dmem_responder
    import types_pkg::*;
#(
    parameter int DATA_W      = DMEM_DATA_W,
    parameter int ADDR_W      = DMEM_ADDR_W,
    parameter int DEPTH       = DMEM_DEPTH_DEF,
    parameter int WAIT_CYCLES = DMEM_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt_sys,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(WAIT_CYCLES);
    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    dmem_state_e       state, state_nxt;
    dmem_req_t         req_q;
    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              resp_enter;
    logic              cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic              cur_in_range;
    logic              wr_in_range;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    assign accept = rst & (state == IDLE) & req_valid & ~halt_sys;
    assign busy   = accept | (state != IDLE);
    assign ack    = (state == RESP);

    // With zero wait states RESP is entered straight from IDLE, before the request
    // is latched, so the read/range path looks at the live request in IDLE.
    assign cur_we       = (state == IDLE) ? req_we   : req_q.we;
    assign cur_addr     = (state == IDLE) ? req_addr : req_q.addr;
    assign cur_in_range = {1'b0, cur_addr} < DEPTH_LIM;
    assign wr_in_range  = {1'b0, req_q.addr} < DEPTH_LIM;
    assign resp_enter   = (state_nxt == RESP) && (state != RESP);
    assign mem_we       = (state == RESP) && req_q.we && wr_in_range;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT: if (cnt <= CNT_W'(1)) state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            req_q <= '0;
            cnt   <= '0;
            rdata <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                req_q <= '{we: req_we, addr: req_addr, wdata: req_wdata};
                cnt   <= CNT_LOAD;
            end else if (state == WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
            // Load data and the range flag are registered on entry to RESP so both
            // are visible during the ack cycle.
            if (resp_enter) begin
                if (!cur_we) begin
                    rdata <= cur_in_range ? mem_rdata : '0;
                end
                if (!cur_in_range) begin
                    err <= 1'b1;
                end
            end
        end
    end

    dmem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (req_q.addr[IDX_W-1:0]),
        .wdata (req_q.wdata),
        .raddr (cur_addr[IDX_W-1:0]),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance 0 has zero wait states, instance 1 has two.
// Load data is predicted from a bench-side memory model and queued until the ack.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt      [2];
    logic        req_valid [2];
    logic        req_we    [2];
    logic [15:0] req_addr  [2];
    logic [15:0] req_wdata [2];
    logic        ack       [2];
    logic [15:0] rdata     [2];
    logic        busy      [2];
    logic        err       [2];

    logic [15:0] exp_q[$];
    logic [15:0] mem_m   [2][256];
    logic [15:0] last_rd [2];
    logic        err_m   [2];
    int checks = 0;
    int passed = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .halt_sys(halt[0]), .req_valid(req_valid[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .ack(ack[0]), .rdata(rdata[0]), .busy(busy[0]), .err(err[0])
    );

    dmem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_CYCLES(2)) u_dut2 (
        .clk(clk), .rst(rst), .halt_sys(halt[1]), .req_valid(req_valid[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .ack(ack[1]), .rdata(rdata[1]), .busy(busy[1]), .err(err[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one transaction on instance s and checks it through its ack cycle.
    // b2b: called at the previous ack cycle with valid still held high.
    task automatic run_txn(input int s, input logic we, input logic [15:0] addr,
                           input logic [15:0] wdata, input bit b2b, input bit keep,
                           input bit raise_halt, input string tag);
        int lat;
        int cyc;
        bit done;
        logic [15:0] exp_rd;
        lat = ((s == 0) ? 0 : 2) + (b2b ? 2 : 1);
        if (!b2b) begin
            @(negedge clk); #1;
            chk({tag, "_idle_busy"}, busy[s], 1'b0);
            chk({tag, "_idle_ack"}, ack[s], 1'b0);
        end
        req_valid[s] = 1'b1;
        req_we[s]    = we;
        req_addr[s]  = addr;
        req_wdata[s] = wdata;
        halt[s]      = 1'b0;
        if (!we) exp_q.push_back((addr < 16'd256) ? mem_m[s][addr[7:0]] : 16'h0000);
        #1;
        if (!b2b) chk({tag, "_accept_busy"}, busy[s], 1'b1);
        cyc  = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk); #1;
            cyc++;
            if (ack[s]) begin
                done = 1'b1;
                chk({tag, "_latency"}, cyc, lat);
                chk({tag, "_ack_busy"}, busy[s], 1'b1);
                if (addr >= 16'd256) err_m[s] = 1'b1;
                chk({tag, "_err"}, err[s], err_m[s]);
                if (!we) begin
                    exp_rd = exp_q.pop_front();
                    last_rd[s] = exp_rd;
                end
                chk({tag, "_rdata"}, rdata[s], last_rd[s]);
                if (we && addr < 16'd256) mem_m[s][addr[7:0]] = wdata;
                if (!keep) req_valid[s] = 1'b0;
                halt[s] = 1'b0;
            end else begin
                chk({tag, "_wait_busy"}, busy[s], 1'b1);
                chk({tag, "_rdata_hold"}, rdata[s], last_rd[s]);
                if (raise_halt && cyc == 1) halt[s] = 1'b1;
                if (cyc > 20) begin
                    chk({tag, "_ack_timeout"}, cyc, lat);
                    if (!we && exp_q.size() > 0) void'(exp_q.pop_back());
                    req_valid[s] = 1'b0;
                    halt[s] = 1'b0;
                    done = 1'b1;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            halt[i] = 1'b0; req_valid[i] = 1'b0; req_we[i] = 1'b0;
            req_addr[i] = '0; req_wdata[i] = '0; last_rd[i] = '0; err_m[i] = 1'b0;
        end
        #12;
        for (int i = 0; i < 2; i++) begin
            chk("reset_ack", ack[i], 1'b0);
            chk("reset_busy", busy[i], 1'b0);
            chk("reset_rdata", rdata[i], 16'h0000);
            chk("reset_err", err[i], 1'b0);
        end
        @(negedge clk);
        rst = 1'b1;

        // Store then load with two wait states.
        run_txn(1, 1'b1, 16'h00A5, 16'hBEEF, 0, 0, 0, "st_a5");
        run_txn(1, 1'b0, 16'h00A5, 16'h0000, 0, 0, 0, "ld_a5");

        // Zero wait states: ack the cycle after accept.
        run_txn(0, 1'b1, 16'h0010, 16'h1234, 0, 0, 0, "w0_st_10");
        run_txn(0, 1'b0, 16'h0010, 16'h0000, 0, 0, 0, "w0_ld_10");

        // Out of range: 0x0100 would alias to word 0 if the range check were missing.
        run_txn(1, 1'b1, 16'h0000, 16'h0000, 0, 0, 0, "st_00");
        run_txn(1, 1'b1, 16'h0100, 16'hFFFF, 0, 0, 0, "oor_st");
        run_txn(1, 1'b0, 16'h0100, 16'h0000, 0, 0, 0, "oor_ld");
        run_txn(1, 1'b0, 16'h0000, 16'h0000, 0, 0, 0, "ld_00_err");
        run_txn(0, 1'b0, 16'hFFFF, 16'h0000, 0, 0, 0, "w0_oor_ld");

        // Halt blocks accepts while a request waits.
        @(negedge clk);
        halt[1] = 1'b1; req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 16'h00A5;
        repeat (5) begin
            #1;
            chk("halt_busy", busy[1], 1'b0);
            chk("halt_ack", ack[1], 1'b0);
            @(negedge clk);
        end
        run_txn(1, 1'b0, 16'h00A5, 16'h0000, 0, 0, 0, "halt_release");
        run_txn(1, 1'b0, 16'h00A5, 16'h0000, 0, 0, 1, "halt_mid");

        // Reset during WAIT abandons the store.
        run_txn(1, 1'b1, 16'h0020, 16'h1111, 0, 0, 0, "st_20_old");
        @(negedge clk); #1;
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 16'h0020; req_wdata[1] = 16'h5555;
        @(negedge clk); #1;
        chk("rstmid_wait_busy", busy[1], 1'b1);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rstmid_ack", ack[i], 1'b0);
            chk("rstmid_busy", busy[i], 1'b0);
            chk("rstmid_rdata", rdata[i], 16'h0000);
            chk("rstmid_err", err[i], 1'b0);
            last_rd[i] = '0;
            err_m[i] = 1'b0;
        end
        req_valid[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_txn(1, 1'b0, 16'h0020, 16'h0000, 0, 0, 0, "ld_20_after_rst");

        // Back-to-back loads with valid held: acks WAIT_CYCLES+2 apart.
        run_txn(1, 1'b0, 16'h00A5, 16'h0000, 0, 1, 0, "b2b_0");
        run_txn(1, 1'b0, 16'h0000, 16'h0000, 1, 1, 0, "b2b_1");
        run_txn(1, 1'b0, 16'h0020, 16'h0000, 1, 0, 0, "b2b_2");
        run_txn(0, 1'b0, 16'h0010, 16'h0000, 0, 1, 0, "w0_b2b_0");
        run_txn(0, 1'b0, 16'h0010, 16'h0000, 1, 0, 0, "w0_b2b_1");

        @(negedge clk); #1;
        chk("end_idle_busy", busy[1], 1'b0);
        chk("end_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
